axis_check: RTL

AXIS_CHECK -- requirements
Module: axis_check

---
 rtl/axis_check_if.sv | 13 +
 rtl/axis_check.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/axis_check_if.sv
// AXI4-Stream subset used by axis_check: data, byte enables, last, valid/ready handshake.
interface axis_check_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_check.sv
// Stream checker: applies a rotating backpressure pattern and checks frame length, a fixed/counter
// data pattern and handshake stability, with sticky flags, saturating counters and an error pulse.
module axis_check #(
    parameter int unsigned                       DATA_WIDTH    = 32,
    parameter int unsigned                       FRAME_LENGTH  = 64,
    parameter int unsigned                       CNTR_WIDTH    = 8,
    parameter logic [DATA_WIDTH-CNTR_WIDTH-1:0] FIXED_DATA    = '1,
    parameter logic [7:0]                        READY_PATTERN = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clr,
    axis_check_if.slave S_AXIS,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        data_err,
    output logic        len_err,
    output logic        proto_err,
    output logic        err_pulse
);
    localparam int unsigned FIX_W  = DATA_WIDTH - CNTR_WIDTH;
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (CNTR_WIDTH > 32) ? CNTR_WIDTH : 32;

    if (CNTR_WIDTH > DATA_WIDTH) begin : g_bad_cntr
        $fatal(1, "axis_check: CNTR_WIDTH exceeds DATA_WIDTH");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "axis_check: DATA_WIDTH is not a multiple of 8");
    end
    if (FRAME_LENGTH < 2) begin : g_bad_len
        $fatal(1, "axis_check: FRAME_LENGTH below 2");
    end

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [7:0]              pattern_q;
    logic                    tready_q;
    logic                    stall_q;
    logic [DATA_WIDTH-1:0]   prev_data_q;
    logic [KEEP_W-1:0]       prev_keep_q;
    logic                    prev_last_q;
    logic [15:0]             frame_cnt_q;
    logic [15:0]             err_cnt_q;
    logic                    data_err_q;
    logic                    len_err_q;
    logic                    proto_err_q;
    logic                    err_pulse_q;

    logic fixed_ok_c;
    logic acc_c;
    logic short_c;
    logic data_bad_c;
    logic len_bad_c;
    logic proto_bad_c;
    logic any_err_c;

    if (FIX_W > 0) begin : g_fixed
        assign fixed_ok_c = (S_AXIS.tdata[DATA_WIDTH-1:CNTR_WIDTH] == FIXED_DATA);
    end else begin : g_no_fixed
        assign fixed_ok_c = 1'b1;
    end

    // Per-cycle error conditions; data/length only matter on accepted beats.
    always_comb begin
        acc_c       = S_AXIS.tvalid & tready_q;
        short_c     = (idx_q < IDX_W'(FRAME_LENGTH - 1));
        data_bad_c  = !fixed_ok_c
                   || (S_AXIS.tdata[CNTR_WIDTH-1:0] != idx_q[CNTR_WIDTH-1:0])
                   || (S_AXIS.tkeep != {KEEP_W{1'b1}});
        len_bad_c   = S_AXIS.tlast ? short_c : !short_c;
        proto_bad_c = stall_q & (!S_AXIS.tvalid
                   || (S_AXIS.tdata != prev_data_q)
                   || (S_AXIS.tkeep != prev_keep_q)
                   || (S_AXIS.tlast != prev_last_q));
        any_err_c   = (acc_c & (data_bad_c | len_bad_c)) | proto_bad_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pattern_q   <= READY_PATTERN;
            tready_q    <= 1'b0;
            stall_q     <= 1'b0;
            prev_data_q <= '0;
            prev_keep_q <= '0;
            prev_last_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            data_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            // Backpressure generation and stall history run independently of clr.
            if (enable) begin
                pattern_q <= {pattern_q[0], pattern_q[7:1]};
            end
            tready_q    <= enable & pattern_q[0];
            stall_q     <= S_AXIS.tvalid & ~tready_q;
            prev_data_q <= S_AXIS.tdata;
            prev_keep_q <= S_AXIS.tkeep;
            prev_last_q <= S_AXIS.tlast;

            if (clr) begin
                state_q     <= IDLE;
                idx_q       <= '0;
                frame_cnt_q <= '0;
                err_cnt_q   <= '0;
                data_err_q  <= 1'b0;
                len_err_q   <= 1'b0;
                proto_err_q <= 1'b0;
                err_pulse_q <= 1'b0;
            end else begin
                err_pulse_q <= any_err_c;
                data_err_q  <= data_err_q  | (acc_c & data_bad_c);
                len_err_q   <= len_err_q   | (acc_c & len_bad_c);
                proto_err_q <= proto_err_q | proto_bad_c;
                if (any_err_c && (err_cnt_q != 16'hFFFF)) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
                // tlast always resynchronises the frame, errored or not.
                if (acc_c) begin
                    if (S_AXIS.tlast) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        if (frame_cnt_q != 16'hFFFF) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                    end else begin
                        state_q <= IN_FRAME;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
            end
        end
    end

    assign S_AXIS.tready = tready_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign data_err      = data_err_q;
    assign len_err       = len_err_q;
    assign proto_err     = proto_err_q;
    assign err_pulse     = err_pulse_q;
endmodule
